// File: rtl/cpu_pkg.sv
// Shared ownership encoding for the data-memory arbiter.
package cpu_pkg;

  localparam logic OWNER_CPU = 1'b0;
  localparam logic OWNER_EXT = 1'b1;

endpackage

// File: rtl/dmem_arbiter_if.sv
// Requester and RAM-side signals of the data-memory arbiter, bundled for port connection.
interface dmem_arbiter_if #(
  parameter int unsigned width       = 16,
  parameter int unsigned daddr_width = 8
);

  logic                   cpu_req;
  logic                   cpu_we;
  logic [daddr_width-1:0] cpu_addr;
  logic [width-1:0]       cpu_wdata;
  logic                   cpu_stall;
  logic                   cpu_rvalid;
  logic [width-1:0]       cpu_rdata;

  logic                   ext_req;
  logic                   ext_we;
  logic [daddr_width-1:0] ext_addr;
  logic [width-1:0]       ext_wdata;
  logic                   ext_lock;
  logic                   ext_gnt;
  logic                   ext_rvalid;
  logic [width-1:0]       ext_rdata;

  logic [daddr_width-1:0] daddr;
  logic                   dwrite;
  logic [width-1:0]       dD;
  logic [width-1:0]       dQ;

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
    input  ext_req, ext_we, ext_addr, ext_wdata, ext_lock,
    input  dQ,
    output cpu_stall, cpu_rvalid, cpu_rdata,
    output ext_gnt, ext_rvalid, ext_rdata,
    output daddr, dwrite, dD
  );

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata,
    output ext_req, ext_we, ext_addr, ext_wdata, ext_lock,
    output dQ,
    input  cpu_stall, cpu_rvalid, cpu_rdata,
    input  ext_gnt, ext_rvalid, ext_rdata,
    input  daddr, dwrite, dD
  );

endinterface

// File: rtl/dmem_arbiter.sv
// Two-port arbiter in front of a single-port synchronous data RAM: round-robin on contention,
// bounded external lock, registered read-valid strobes and a saturating CPU stall counter.
module dmem_arbiter
  import cpu_pkg::*;
#(
  parameter int unsigned width       = 16,
  parameter int unsigned daddr_width = 8,
  parameter int unsigned lock_max    = 8,
  parameter int unsigned cnt_width   = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  dmem_arbiter_if.slave        bus,
  output logic [cnt_width-1:0] stall_count
);

  localparam int unsigned LockW = $clog2(lock_max + 1);
  localparam logic [LockW-1:0] LockMax = LockW'(lock_max);

  logic                   last_owner_q;
  logic [LockW-1:0]       lock_cnt_q;
  logic                   cpu_rvalid_q;
  logic                   ext_rvalid_q;
  logic [cnt_width-1:0]   stall_count_q;

  logic                   cpu_gnt;
  logic                   ext_gnt;
  logic                   cpu_stall;
  logic                   lock_expired;
  logic                   lock_hold;
  logic [daddr_width-1:0] addr_mux;
  logic [width-1:0]       wdata_mux;

  // Grants stay low during reset so no RAM write can slip through.
  always_comb begin
    lock_expired = (lock_cnt_q == LockMax);
    lock_hold    = bus.ext_req & bus.ext_lock & (lock_cnt_q != '0) & ~lock_expired;
    cpu_gnt      = 1'b0;
    ext_gnt      = 1'b0;
    if (!reset) begin
      if (lock_expired) begin
        cpu_gnt = bus.cpu_req;
      end else if (lock_hold) begin
        ext_gnt = 1'b1;
      end else if (bus.cpu_req && bus.ext_req) begin
        if (last_owner_q == OWNER_EXT) cpu_gnt = 1'b1;
        else                           ext_gnt = 1'b1;
      end else begin
        cpu_gnt = bus.cpu_req;
        ext_gnt = bus.ext_req;
      end
    end
  end

  always_comb begin
    addr_mux  = bus.cpu_addr;
    wdata_mux = bus.cpu_wdata;
    if (ext_gnt) begin
      addr_mux  = bus.ext_addr;
      wdata_mux = bus.ext_wdata;
    end
  end

  assign cpu_stall      = bus.cpu_req & ~cpu_gnt;
  assign bus.cpu_stall  = cpu_stall;
  assign bus.ext_gnt    = ext_gnt;
  assign bus.daddr      = addr_mux;
  assign bus.dD         = wdata_mux;
  assign bus.dwrite     = (cpu_gnt & bus.cpu_we) | (ext_gnt & bus.ext_we);
  // Masking with reset drops the strobe of a read granted just before reset.
  assign bus.cpu_rvalid = cpu_rvalid_q & ~reset;
  assign bus.ext_rvalid = ext_rvalid_q & ~reset;
  assign bus.cpu_rdata  = bus.dQ;
  assign bus.ext_rdata  = bus.dQ;
  assign stall_count    = stall_count_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      last_owner_q  <= OWNER_EXT;
      lock_cnt_q    <= '0;
      cpu_rvalid_q  <= 1'b0;
      ext_rvalid_q  <= 1'b0;
      stall_count_q <= '0;
    end else begin
      if (cpu_gnt)      last_owner_q <= OWNER_CPU;
      else if (ext_gnt) last_owner_q <= OWNER_EXT;

      if (lock_expired || !bus.ext_req || !bus.ext_lock) lock_cnt_q <= '0;
      else if (ext_gnt)                                  lock_cnt_q <= lock_cnt_q + 1'b1;

      cpu_rvalid_q <= cpu_gnt & ~bus.cpu_we;
      ext_rvalid_q <= ext_gnt & ~bus.ext_we;

      if (cpu_stall && (stall_count_q != '1)) stall_count_q <= stall_count_q + 1'b1;
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: directed scenarios plus a randomized run
// against a behavioural model of grants, lock runs, read data and the stall counter.
module tb_dmem_arbiter;

  localparam int unsigned W       = 16;
  localparam int unsigned AW      = 8;
  localparam int          LockMx  = 8;
  localparam int unsigned CntW    = 4;
  localparam int          CntMax  = (1 << CntW) - 1;

  typedef struct {
    bit          rst;
    bit          c_req;
    bit          c_we;
    logic [7:0]  c_addr;
    logic [15:0] c_wd;
    bit          e_req;
    bit          e_we;
    bit          e_lock;
    logic [7:0]  e_addr;
    logic [15:0] e_wd;
  } stim_t;

  logic            clk = 1'b0;
  logic            reset;
  logic [CntW-1:0] stall_count;

  dmem_arbiter_if #(.width(W), .daddr_width(AW)) bus ();

  dmem_arbiter #(
    .width      (W),
    .daddr_width(AW),
    .lock_max   (LockMx),
    .cnt_width  (CntW)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .bus        (bus),
    .stall_count(stall_count)
  );

  always #5 clk = ~clk;

  // Environment RAM: single port, 1-cycle read latency, with a preload path for the bench.
  logic [W-1:0]  ram [256];
  logic [W-1:0]  dq_q;
  logic          pre_we;
  logic [7:0]    pre_addr;
  logic [15:0]   pre_data;

  always @(posedge clk) begin
    if (pre_we)          ram[pre_addr] <= pre_data;
    else if (bus.dwrite) ram[bus.daddr] <= bus.dD;
    dq_q <= ram[bus.daddr];
  end
  assign bus.dQ = dq_q;

  int checks   = 0;
  int failures = 0;

  // Reference model state
  stim_t       s;
  logic [15:0] sh [256];
  bit          m_last_ext;
  int          m_run;
  bit          m_cpu_rv, m_ext_rv;
  logic [15:0] m_rdata;
  int          m_stall;

  // Expectations for the current cycle
  bit          x_cpu_gnt, x_ext_gnt, x_cpu_rv, x_ext_rv, x_dwrite;
  logic [7:0]  x_daddr;
  logic [15:0] x_dd, x_rdata;
  int          x_stall;

  // Drive one cycle of stimulus, derive this cycle's expectations, advance the model.
  task automatic cycle();
    @(posedge clk);
    #1;
    reset         = s.rst;
    bus.cpu_req   = s.c_req;
    bus.cpu_we    = s.c_we;
    bus.cpu_addr  = s.c_addr;
    bus.cpu_wdata = s.c_wd;
    bus.ext_req   = s.e_req;
    bus.ext_we    = s.e_we;
    bus.ext_addr  = s.e_addr;
    bus.ext_wdata = s.e_wd;
    bus.ext_lock  = s.e_lock;

    x_cpu_gnt = 1'b0;
    x_ext_gnt = 1'b0;
    if (!s.rst) begin
      if (m_run == LockMx)                           x_cpu_gnt = s.c_req;
      else if (m_run > 0 && s.e_req && s.e_lock)     x_ext_gnt = 1'b1;
      else if (s.c_req && s.e_req) begin
        if (m_last_ext) x_cpu_gnt = 1'b1;
        else            x_ext_gnt = 1'b1;
      end else begin
        x_cpu_gnt = s.c_req;
        x_ext_gnt = s.e_req;
      end
    end
    x_cpu_rv = m_cpu_rv && !s.rst;
    x_ext_rv = m_ext_rv && !s.rst;
    x_rdata  = m_rdata;
    x_stall  = m_stall;
    x_dwrite = (x_cpu_gnt && s.c_we) || (x_ext_gnt && s.e_we);
    x_daddr  = x_ext_gnt ? s.e_addr : s.c_addr;
    x_dd     = x_ext_gnt ? s.e_wd : s.c_wd;

    if (s.rst) begin
      m_last_ext = 1'b1;
      m_run      = 0;
      m_cpu_rv   = 1'b0;
      m_ext_rv   = 1'b0;
      m_stall    = 0;
    end else begin
      if (x_cpu_gnt)      m_last_ext = 1'b0;
      else if (x_ext_gnt) m_last_ext = 1'b1;
      if (m_run == LockMx || !s.e_req || !s.e_lock) m_run = 0;
      else if (x_ext_gnt)                           m_run++;
      m_cpu_rv = x_cpu_gnt && !s.c_we;
      m_ext_rv = x_ext_gnt && !s.e_we;
      if (x_cpu_gnt) begin
        if (s.c_we) sh[s.c_addr] = s.c_wd;
        else        m_rdata = sh[s.c_addr];
      end
      if (x_ext_gnt) begin
        if (s.e_we) sh[s.e_addr] = s.e_wd;
        else        m_rdata = sh[s.e_addr];
      end
      if (s.c_req && !x_cpu_gnt && m_stall < CntMax) m_stall++;
    end
    @(negedge clk);
  endtask

  task automatic idle_stim(input bit rst);
    s = '{rst: rst, c_req: 0, c_we: 0, c_addr: 8'h00, c_wd: 16'h0000,
          e_req: 0, e_we: 0, e_lock: 0, e_addr: 8'h00, e_wd: 16'h0000};
  endtask

  task automatic preload();
    idle_stim(1'b1);
    reset = 1'b1;
    for (int i = 0; i < 256; i++) begin
      @(posedge clk);
      #1;
      pre_we   = 1'b1;
      pre_addr = 8'(i);
      pre_data = (i == 8'h12) ? 16'h1234 : 16'($urandom);
      sh[i]    = pre_data;
    end
    @(posedge clk);
    #1;
    pre_we = 1'b0;
    cycle();
  endtask

  task automatic test_reset();
    s = '{rst: 1, c_req: 1, c_we: 0, c_addr: 8'h12, c_wd: 16'h0,
          e_req: 1, e_we: 1, e_lock: 0, e_addr: 8'h55, e_wd: 16'hA5A5};
    cycle();
    checks++;
    if (bus.cpu_stall !== 1'b1) begin
      failures++; $display("FAIL reset_cpu_stall got=%b exp=1", bus.cpu_stall);
    end
    checks++;
    if (bus.dwrite !== 1'b0) begin
      failures++; $display("FAIL reset_dwrite got=%b exp=0", bus.dwrite);
    end
    checks++;
    if (bus.ext_gnt !== 1'b0) begin
      failures++; $display("FAIL reset_ext_gnt got=%b exp=0", bus.ext_gnt);
    end
    checks++;
    if (bus.cpu_rvalid !== 1'b0 || bus.ext_rvalid !== 1'b0) begin
      failures++;
      $display("FAIL reset_rvalid got=%b%b exp=00", bus.cpu_rvalid, bus.ext_rvalid);
    end
    idle_stim(1'b0);
    cycle();
    checks++;
    if (stall_count !== '0) begin
      failures++; $display("FAIL reset_stall_count got=%0d exp=0", stall_count);
    end
  endtask

  task automatic test_cpu_read();
    idle_stim(1'b0);
    s.c_req  = 1'b1;
    s.c_addr = 8'h12;
    cycle();
    checks++;
    if (bus.cpu_stall !== 1'b0 || bus.daddr !== 8'h12 || bus.dwrite !== 1'b0) begin
      failures++;
      $display("FAIL cpu_read_issue got stall=%b daddr=%h dwrite=%b exp stall=0 daddr=12 dwrite=0",
               bus.cpu_stall, bus.daddr, bus.dwrite);
    end
    idle_stim(1'b0);
    cycle();
    checks++;
    if (bus.cpu_rvalid !== 1'b1 || bus.cpu_rdata !== 16'h1234) begin
      failures++;
      $display("FAIL cpu_read_return got rvalid=%b rdata=%h exp rvalid=1 rdata=1234",
               bus.cpu_rvalid, bus.cpu_rdata);
    end
    checks++;
    if (bus.ext_rvalid !== 1'b0) begin
      failures++; $display("FAIL cpu_read_ext_rvalid got=%b exp=0", bus.ext_rvalid);
    end
  endtask

  task automatic test_contention();
    int rv_seen = 0;
    idle_stim(1'b1);
    cycle();
    s = '{rst: 0, c_req: 1, c_we: 0, c_addr: 8'h20, c_wd: 16'h0,
          e_req: 1, e_we: 1, e_lock: 0, e_addr: 8'h20, e_wd: 16'hBEEF};
    for (int i = 0; i < 6; i++) begin
      cycle();
      checks++;
      if (bus.cpu_stall !== 1'(i % 2) || bus.ext_gnt !== 1'(i % 2)) begin
        failures++;
        $display("FAIL contention_grant cyc=%0d got stall=%b ext_gnt=%b exp both=%0d",
                 i, bus.cpu_stall, bus.ext_gnt, i % 2);
      end
      checks++;
      if (stall_count !== CntW'(i / 2)) begin
        failures++;
        $display("FAIL contention_stall_count cyc=%0d got=%0d exp=%0d", i, stall_count, i / 2);
      end
      checks++;
      if (bus.cpu_rvalid !== 1'(i % 2)) begin
        failures++;
        $display("FAIL contention_rvalid cyc=%0d got=%b exp=%0d", i, bus.cpu_rvalid, i % 2);
      end
      if (bus.cpu_rvalid === 1'b1) begin
        rv_seen++;
        checks++;
        if (rv_seen == 2 && bus.cpu_rdata !== 16'hBEEF) begin
          failures++;
          $display("FAIL contention_second_read got=%h exp=beef", bus.cpu_rdata);
        end else if (rv_seen != 2 && bus.cpu_rdata !== x_rdata) begin
          failures++;
          $display("FAIL contention_read cyc=%0d got=%h exp=%h", i, bus.cpu_rdata, x_rdata);
        end
      end
    end
  endtask

  task automatic test_lock();
    idle_stim(1'b1);
    cycle();
    s = '{rst: 0, c_req: 1, c_we: 0, c_addr: 8'h03, c_wd: 16'h0,
          e_req: 1, e_we: 1, e_lock: 1, e_addr: 8'h40, e_wd: 16'h1111};
    for (int i = 0; i < 20; i++) begin
      cycle();
      checks++;
      if (bus.ext_gnt !== ((i % 9) != 0) || bus.cpu_stall !== ((i % 9) != 0)) begin
        failures++;
        $display("FAIL lock_grant cyc=%0d got ext_gnt=%b stall=%b exp ext_gnt=%b",
                 i, bus.ext_gnt, bus.cpu_stall, (i % 9) != 0);
      end
      checks++;
      if (stall_count !== CntW'(x_stall)) begin
        failures++;
        $display("FAIL lock_stall_count cyc=%0d got=%0d exp=%0d", i, stall_count, x_stall);
      end
    end
  endtask

  task automatic test_lock_drop();
    bit exp_ext [6];
    bit lock    [6];
    exp_ext = '{0, 1, 1, 1, 0, 1};
    lock    = '{0, 1, 1, 1, 0, 0};
    idle_stim(1'b1);
    cycle();
    s = '{rst: 0, c_req: 1, c_we: 0, c_addr: 8'h07, c_wd: 16'h0,
          e_req: 1, e_we: 0, e_lock: 0, e_addr: 8'h08, e_wd: 16'h0};
    for (int i = 0; i < 6; i++) begin
      s.e_lock = lock[i];
      cycle();
      checks++;
      if (bus.ext_gnt !== exp_ext[i] || bus.cpu_stall !== exp_ext[i]) begin
        failures++;
        $display("FAIL lock_drop_grant cyc=%0d got ext_gnt=%b stall=%b exp ext_gnt=%b",
                 i, bus.ext_gnt, bus.cpu_stall, exp_ext[i]);
      end
    end
  endtask

  task automatic test_reset_mid();
    idle_stim(1'b1);
    cycle();
    idle_stim(1'b0);
    s.c_req  = 1'b1;
    s.c_addr = 8'h12;
    cycle();
    checks++;
    if (bus.cpu_stall !== 1'b0) begin
      failures++; $display("FAIL reset_mid_grant got stall=%b exp=0", bus.cpu_stall);
    end
    s = '{rst: 1, c_req: 0, c_we: 0, c_addr: 8'h12, c_wd: 16'h0,
          e_req: 1, e_we: 1, e_lock: 1, e_addr: 8'h12, e_wd: 16'hDEAD};
    cycle();
    checks++;
    if (bus.cpu_rvalid !== 1'b0 || bus.dwrite !== 1'b0 || bus.ext_gnt !== 1'b0) begin
      failures++;
      $display("FAIL reset_mid_suppress got rvalid=%b dwrite=%b ext_gnt=%b exp 0 0 0",
               bus.cpu_rvalid, bus.dwrite, bus.ext_gnt);
    end
    s.rst   = 1'b0;
    s.c_req = 1'b1;
    cycle();
    checks++;
    if (bus.cpu_stall !== 1'b0 || bus.ext_gnt !== 1'b0 || stall_count !== '0 ||
        bus.cpu_rvalid !== 1'b0) begin
      failures++;
      $display("FAIL reset_mid_after got stall=%b ext_gnt=%b cnt=%0d rvalid=%b exp 0 0 0 0",
               bus.cpu_stall, bus.ext_gnt, stall_count, bus.cpu_rvalid);
    end
  endtask

  task automatic test_saturation();
    idle_stim(1'b1);
    cycle();
    s = '{rst: 0, c_req: 1, c_we: 0, c_addr: 8'h01, c_wd: 16'h0,
          e_req: 1, e_we: 0, e_lock: 1, e_addr: 8'h02, e_wd: 16'h0};
    for (int i = 0; i < 25; i++) begin
      cycle();
      checks++;
      if (stall_count !== CntW'(x_stall)) begin
        failures++;
        $display("FAIL sat_count cyc=%0d got=%0d exp=%0d", i, stall_count, x_stall);
      end
    end
    checks++;
    if (stall_count !== 4'hF) begin
      failures++; $display("FAIL sat_hold got=%h exp=f", stall_count);
    end
  endtask

  task automatic test_random();
    bit c_pend = 1'b0;
    bit e_pend = 1'b0;
    idle_stim(1'b1);
    cycle();
    s.rst = 1'b0;
    for (int i = 0; i < 400; i++) begin
      if (!c_pend) begin
        s.c_req  = ($urandom_range(0, 3) != 0);
        s.c_we   = 1'($urandom_range(0, 1));
        s.c_addr = 8'($urandom_range(0, 15));
        s.c_wd   = 16'($urandom);
      end
      if (!e_pend) begin
        s.e_req  = ($urandom_range(0, 2) != 0);
        s.e_we   = 1'($urandom_range(0, 1));
        s.e_addr = 8'($urandom_range(0, 15));
        s.e_wd   = 16'($urandom);
      end
      if ($urandom_range(0, 7) == 0) s.e_lock = !s.e_lock;
      s.rst = ($urandom_range(0, 63) == 0);
      cycle();
      checks++;
      if (bus.cpu_stall !== (s.c_req && !x_cpu_gnt) || bus.ext_gnt !== x_ext_gnt) begin
        failures++;
        $display("FAIL rand_grant cyc=%0d got stall=%b ext_gnt=%b exp stall=%b ext_gnt=%b",
                 i, bus.cpu_stall, bus.ext_gnt, s.c_req && !x_cpu_gnt, x_ext_gnt);
      end
      checks++;
      if (bus.dwrite !== x_dwrite || bus.daddr !== x_daddr || bus.dD !== x_dd) begin
        failures++;
        $display("FAIL rand_ram cyc=%0d got we=%b a=%h d=%h exp we=%b a=%h d=%h",
                 i, bus.dwrite, bus.daddr, bus.dD, x_dwrite, x_daddr, x_dd);
      end
      checks++;
      if (bus.cpu_rvalid !== x_cpu_rv || bus.ext_rvalid !== x_ext_rv) begin
        failures++;
        $display("FAIL rand_rvalid cyc=%0d got cpu=%b ext=%b exp cpu=%b ext=%b",
                 i, bus.cpu_rvalid, bus.ext_rvalid, x_cpu_rv, x_ext_rv);
      end
      if (x_cpu_rv || x_ext_rv) begin
        checks++;
        if ((x_cpu_rv && bus.cpu_rdata !== x_rdata) || (x_ext_rv && bus.ext_rdata !== x_rdata)) begin
          failures++;
          $display("FAIL rand_rdata cyc=%0d got cpu=%h ext=%h exp=%h",
                   i, bus.cpu_rdata, bus.ext_rdata, x_rdata);
        end
      end
      checks++;
      if (stall_count !== CntW'(x_stall)) begin
        failures++;
        $display("FAIL rand_stall_count cyc=%0d got=%0d exp=%0d", i, stall_count, x_stall);
      end
      c_pend = s.c_req && !x_cpu_gnt;
      e_pend = s.e_req && !x_ext_gnt;
    end
  endtask

  initial begin
    reset         = 1'b1;
    pre_we        = 1'b0;
    pre_addr      = 8'h00;
    pre_data      = 16'h0000;
    bus.cpu_req   = 1'b0;
    bus.cpu_we    = 1'b0;
    bus.cpu_addr  = '0;
    bus.cpu_wdata = '0;
    bus.ext_req   = 1'b0;
    bus.ext_we    = 1'b0;
    bus.ext_addr  = '0;
    bus.ext_wdata = '0;
    bus.ext_lock  = 1'b0;
    m_last_ext    = 1'b1;
    m_run         = 0;
    m_cpu_rv      = 1'b0;
    m_ext_rv      = 1'b0;
    m_rdata       = '0;
    m_stall       = 0;

    preload();
    test_reset();
    test_cpu_read();
    test_contention();
    test_lock();
    test_lock_drop();
    test_reset_mid();
    test_saturation();
    test_random();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
